// File: rtl/uart_loader.sv
// Serial program loader: receives 8N1 frames on ftdi_rx and writes their payload
// into program memory while holding the CPU off the shared memory port.
module uart_loader #(
    parameter int CLK_HZ  = 25000000,
    parameter int BAUD    = 230400,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 2500000
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              ftdi_rx,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    output logic              o_wr,
    output logic              cpu_hold,
    output logic              ok,
    output logic              err
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_ADDR_L,
        F_ADDR_H,
        F_LEN_L,
        F_LEN_H,
        F_DATA,
        F_CSUM
    } frame_state_t;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    frame_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic [TMO_W-1:0]  tmo_cnt;

    // Receiver: sync the line, confirm the start bit at mid-bit, then sample
    // each data bit and the stop bit at their centres.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= ftdi_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign sum_next = sum + rx_byte;

    // Frame parser: once synced, every byte feeds the checksum; a framing error
    // or a too-long gap between bytes abandons the frame.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state    <= F_IDLE;
            addr     <= '0;
            len      <= '0;
            sum      <= '0;
            tmo_cnt  <= '0;
            o_addr   <= '0;
            o_data   <= '0;
            o_wr     <= 1'b0;
            cpu_hold <= 1'b0;
            ok       <= 1'b0;
            err      <= 1'b0;
        end else begin
            o_wr <= 1'b0;
            ok   <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        sum      <= '0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= F_ADDR_L;
                    end
                end
                default: begin
                    if (rx_ferr || (!rx_valid && tmo_cnt == TMO_LAST)) begin
                        err      <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= F_IDLE;
                    end else if (!rx_valid) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end else begin
                        tmo_cnt <= '0;
                        sum     <= sum_next;
                        case (state)
                            F_ADDR_L: begin
                                addr  <= ADDR_W'(rx_byte);
                                state <= F_ADDR_H;
                            end
                            F_ADDR_H: begin
                                addr  <= ADDR_W'({rx_byte, addr[7:0]});
                                state <= F_LEN_L;
                            end
                            F_LEN_L: begin
                                len   <= {8'h00, rx_byte};
                                state <= F_LEN_H;
                            end
                            F_LEN_H: begin
                                len   <= {rx_byte, len[7:0]};
                                state <= ({rx_byte, len[7:0]} != 16'h0000) ? F_DATA : F_CSUM;
                            end
                            F_DATA: begin
                                o_addr <= addr;
                                o_data <= rx_byte;
                                o_wr   <= 1'b1;
                                addr   <= addr + ADDR_W'(1);
                                len    <= len - 16'd1;
                                if (len == 16'd1) begin
                                    state <= F_CSUM;
                                end
                            end
                            F_CSUM: begin
                                if (sum_next == 8'h00) begin
                                    ok <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                                cpu_hold <= 1'b0;
                                state    <= F_IDLE;
                            end
                            default: state <= F_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table vectors, random frames against a frame-level
// model, and hand-written sequences for timeout, framing error, reset and glitch.
module tb_uart_loader;

    localparam int CLK_HZ  = 160;
    localparam int BAUD    = 10;
    localparam int BIT     = CLK_HZ / BAUD;
    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 400;

    logic              clock_25 = 1'b0;
    logic              reset;
    logic              ftdi_rx;
    logic [ADDR_W-1:0] o_addr;
    logic [7:0]        o_data;
    logic              o_wr;
    logic              cpu_hold;
    logic              ok;
    logic              err;

    always #5 clock_25 = ~clock_25;

    uart_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_25(clock_25),
        .reset   (reset),
        .ftdi_rx (ftdi_rx),
        .o_addr  (o_addr),
        .o_data  (o_data),
        .o_wr    (o_wr),
        .cpu_hold(cpu_hold),
        .ok      (ok),
        .err     (err)
    );

    int tests = 0;
    int fails = 0;

    // Monitor: logs every write and checks strobe width and cpu_hold edges.
    logic [ADDR_W-1:0] got_addr[$];
    logic [7:0]        got_data[$];
    int   ok_seen   = 0;
    int   hold_viol = 0;
    int   wr_viol   = 0;
    logic prev_hold = 1'b0;
    logic prev_wr   = 1'b0;
    logic prev_err  = 1'b0;

    always @(negedge clock_25) begin
        if (o_wr === 1'b1) begin
            got_addr.push_back(o_addr);
            got_data.push_back(o_data);
            if (cpu_hold !== 1'b1 || prev_wr === 1'b1) wr_viol++;
        end
        if (ok === 1'b1) begin
            ok_seen++;
            if (!(prev_hold === 1'b1 && cpu_hold === 1'b0)) hold_viol++;
        end
        if (err === 1'b1 && prev_err === 1'b0 && reset === 1'b0) begin
            if (!(prev_hold === 1'b1 && cpu_hold === 1'b0)) hold_viol++;
        end
        prev_hold = cpu_hold;
        prev_wr   = o_wr;
        prev_err  = err;
    end

    int base_wr, base_ok, base_hv, base_wv;

    task automatic mark();
        base_wr = got_addr.size();
        base_ok = ok_seen;
        base_hv = hold_viol;
        base_wv = wr_viol;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ftdi_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            ftdi_rx = b[i];
            idle(BIT);
        end
        ftdi_rx = stop;
        idle(BIT);
        ftdi_rx = 1'b1;
        idle(4);
    endtask

    // Frame-level reference model: derives writes and result from the frame bytes.
    logic [7:0]        frm[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [7:0]        exp_data[$];
    int                exp_ok;
    logic              exp_err;

    task automatic model_frame();
        int         a;
        int         n;
        logic [7:0] s;
        exp_addr.delete();
        exp_data.delete();
        a = {frm[2], frm[1]};
        n = {frm[4], frm[3]};
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'(a % (1 << ADDR_W)));
            exp_data.push_back(frm[5 + i]);
            a++;
        end
        s = 8'h00;
        for (int i = 1; i < frm.size(); i++) s = s + frm[i];
        exp_ok  = (s == 8'h00) ? 1 : 0;
        exp_err = (s != 8'h00);
    endtask

    task automatic check_frame(input string tag);
        int nwr;
        nwr = got_addr.size() - base_wr;
        check_output({tag, ".nwr"}, nwr, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < nwr; i++) begin
            check_output($sformatf("%s.addr%0d", tag, i), got_addr[base_wr + i], exp_addr[i]);
            check_output($sformatf("%s.data%0d", tag, i), got_data[base_wr + i], exp_data[i]);
        end
        check_output({tag, ".ok"}, ok_seen - base_ok, exp_ok);
        check_output({tag, ".err"}, err, exp_err);
        check_output({tag, ".hold"}, cpu_hold, 0);
        check_output({tag, ".hold_edges"}, hold_viol - base_hv, 0);
        check_output({tag, ".wr_strobe"}, wr_viol - base_wv, 0);
    endtask

    task automatic apply_stimulus(input string tag);
        model_frame();
        mark();
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        idle(8);
        check_frame(tag);
    endtask

    task automatic load_frame(input logic [79:0] fr, input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(fr[79 - 8 * i -: 8]);
    endtask

    typedef struct {
        logic [79:0]       fr;
        int                n;
        int                nwr;
        logic [ADDR_W-1:0] a0;
        logic [7:0]        d0;
        logic [ADDR_W-1:0] al;
        logic [7:0]        dl;
        int                okc;
        logic              e;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [79:0] fr, input int n, input int nwr,
                           input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                           input logic [ADDR_W-1:0] al, input logic [7:0] dl,
                           input int okc, input logic e);
        vec_t v;
        v.fr = fr; v.n = n; v.nwr = nwr;
        v.a0 = a0; v.d0 = d0; v.al = al; v.dl = dl;
        v.okc = okc; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        add_vec(80'hA5_00_01_03_00_11_22_33_96_00, 9, 3, 14'h0100, 8'h11, 14'h0102, 8'h33, 1, 1'b0);
        add_vec(80'hA5_00_01_03_00_11_22_33_99_00, 9, 3, 14'h0100, 8'h11, 14'h0102, 8'h33, 0, 1'b1);
        add_vec(80'hA5_00_01_03_00_11_22_33_96_00, 9, 3, 14'h0100, 8'h11, 14'h0102, 8'h33, 1, 1'b0);
        add_vec(80'hA5_FF_3F_02_00_AA_BB_5B_00_00, 8, 2, 14'h3FFF, 8'hAA, 14'h0000, 8'hBB, 1, 1'b0);
        add_vec(80'hA5_00_00_00_00_00_00_00_00_00, 6, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 1, 1'b0);
        add_vec(80'hA5_34_C2_01_00_5A_AF_00_00_00, 7, 1, 14'h0234, 8'h5A, 14'h0234, 8'h5A, 1, 1'b0);

        reset   = 1'b1;
        ftdi_rx = 1'b1;
        idle(3);
        check_output("rst.o_addr", o_addr, 0);
        check_output("rst.o_data", o_data, 0);
        check_output("rst.o_wr", o_wr, 0);
        check_output("rst.cpu_hold", cpu_hold, 0);
        check_output("rst.ok", ok, 0);
        check_output("rst.err", err, 0);
        reset = 1'b0;
        idle(20);

        foreach (tbl[k]) begin
            int nwr;
            load_frame(tbl[k].fr, tbl[k].n);
            apply_stimulus($sformatf("vec%0d", k));
            nwr = got_addr.size() - base_wr;
            check_output($sformatf("vec%0d.tbl_nwr", k), nwr, tbl[k].nwr);
            if (tbl[k].nwr > 0 && nwr == tbl[k].nwr) begin
                check_output($sformatf("vec%0d.tbl_a0", k), got_addr[base_wr], tbl[k].a0);
                check_output($sformatf("vec%0d.tbl_d0", k), got_data[base_wr], tbl[k].d0);
                check_output($sformatf("vec%0d.tbl_al", k), got_addr[base_wr + nwr - 1], tbl[k].al);
                check_output($sformatf("vec%0d.tbl_dl", k), got_data[base_wr + nwr - 1], tbl[k].dl);
            end
            check_output($sformatf("vec%0d.tbl_ok", k), ok_seen - base_ok, tbl[k].okc);
            check_output($sformatf("vec%0d.tbl_err", k), err, tbl[k].e);
        end

        // Bad checksum leaves err set until the next sync byte, then a stalled frame times out.
        load_frame(80'hA5_00_01_03_00_11_22_33_99_00, 9);
        apply_stimulus("bad_csum");
        idle(100);
        check_output("err_sticky", err, 1);
        mark();
        send_byte(8'hA5, 1'b1);
        check_output("sync_clears_err", err, 0);
        check_output("hold_after_sync", cpu_hold, 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(370);
        check_output("tmo_early.hold", cpu_hold, 1);
        check_output("tmo_early.err", err, 0);
        idle(60);
        check_output("tmo.err", err, 1);
        check_output("tmo.hold", cpu_hold, 0);
        check_output("tmo.nwr", got_addr.size() - base_wr, 0);
        check_output("tmo.hold_edges", hold_viol - base_hv, 0);

        // Framing error in a data byte aborts the frame; the first write stays.
        idle(20);
        mark();
        load_frame(80'hA5_00_01_03_00_11_00_00_00_00, 6);
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        send_byte(8'h22, 1'b0);
        idle(4);
        check_output("ferr.err", err, 1);
        check_output("ferr.hold", cpu_hold, 0);
        check_output("ferr.nwr", got_addr.size() - base_wr, 1);
        if (got_addr.size() - base_wr >= 1) begin
            check_output("ferr.addr0", got_addr[base_wr], 14'h0100);
            check_output("ferr.data0", got_data[base_wr], 8'h11);
        end
        check_output("ferr.hold_edges", hold_viol - base_hv, 0);

        // A framing error while idle is ignored.
        load_frame(80'hA5_00_00_00_00_00_00_00_00_00, 6);
        apply_stimulus("clear_err");
        send_byte(8'hA5, 1'b0);
        idle(20);
        check_output("idle_ferr.err", err, 0);
        check_output("idle_ferr.hold", cpu_hold, 0);

        // Reset in the middle of a data byte.
        mark();
        load_frame(80'hA5_00_01_03_00_11_00_00_00_00, 6);
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        check_output("prerst.nwr", got_addr.size() - base_wr, 1);
        ftdi_rx = 1'b0; idle(BIT);
        ftdi_rx = 1'b1; idle(BIT);
        ftdi_rx = 1'b0; idle(BIT + 4);
        reset = 1'b1;
        idle(2);
        check_output("midrst.o_addr", o_addr, 0);
        check_output("midrst.o_data", o_data, 0);
        check_output("midrst.o_wr", o_wr, 0);
        check_output("midrst.cpu_hold", cpu_hold, 0);
        check_output("midrst.ok", ok, 0);
        check_output("midrst.err", err, 0);
        ftdi_rx = 1'b1;
        reset   = 1'b0;
        idle(200);
        load_frame(80'hA5_00_01_03_00_11_22_33_96_00, 9);
        apply_stimulus("after_rst");

        // Short low glitch between frame bytes must not produce a byte.
        load_frame(80'hA5_00_02_01_00_77_86_00_00_00, 7);
        model_frame();
        mark();
        for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b1);
        ftdi_rx = 1'b0; idle(4);
        ftdi_rx = 1'b1; idle(40);
        send_byte(frm[5], 1'b1);
        send_byte(frm[6], 1'b1);
        idle(8);
        check_frame("glitch");

        for (int k = 0; k < 20; k++) begin
            logic [15:0] a;
            int          n;
            logic [7:0]  s;
            a = 16'($urandom);
            n = $urandom_range(0, 4);
            frm.delete();
            frm.push_back(8'hA5);
            frm.push_back(a[7:0]);
            frm.push_back(a[15:8]);
            frm.push_back(8'(n));
            frm.push_back(8'h00);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            s = 8'h00;
            for (int i = 1; i < frm.size(); i++) s = s + frm[i];
            s = 8'h00 - s;
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            frm.push_back(s);
            apply_stimulus($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
